// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and mode constants for downcount_timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/downcount_timer.sv
// rtl/downcount_timer.sv - loadable down-counter with one-shot or auto-reload terminal count
module downcount_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_mode;
  logic             r_tc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_mode_nxt;
  logic             w_tc_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_tc_nxt     = 1'b0;

    if (load) begin
      // A zero load parks the timer instead of producing an immediate terminal count.
      if (load_val != '0) begin
        w_q_nxt      = load_val;
        w_reload_nxt = load_val;
        w_mode_nxt   = mode;
        w_state_nxt  = RUN;
      end else begin
        w_q_nxt     = '0;
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        RUN: begin
          if (en) begin
            if (r_q > WIDTH'(1)) begin
              w_q_nxt = r_q - WIDTH'(1);
            end else if (r_q == WIDTH'(1)) begin
              w_tc_nxt = 1'b1;
              if (r_mode == MODE_AUTO) begin
                w_q_nxt = r_reload;
              end else begin
                w_q_nxt     = '0;
                w_state_nxt = DONE;
              end
            end
          end
        end
        DONE: begin
          w_q_nxt = '0;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_mode   <= MODE_ONESHOT;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_downcount_timer.sv
// tb/tb_downcount_timer.sv - directed self-checking bench for downcount_timer (WIDTH=3)
module tb_downcount_timer;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         mode;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;
  int tc_count;

  downcount_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
    if (tc) tc_count++;
  endtask

  task automatic chk_all(input string tag, input int eq, input int etc, input int ebusy, input int edone);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".tc"}, int'(tc), etc);
    chk({tag, ".busy"}, int'(busy), ebusy);
    chk({tag, ".done"}, int'(done), edone);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tc_count = 0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0;

    edge1();
    chk_all("reset", 0, 0, 0, 0);

    // 1: reset mid-RUN aborts without tc
    rst_n = 1'b1; load = 1'b1; load_val = 3'd5; mode = 1'b0; en = 1'b1;
    edge1();
    chk_all("t1_load", 5, 0, 1, 0);
    load = 1'b0;
    edge1();
    edge1();
    chk_all("t1_q3", 3, 0, 1, 0);
    rst_n = 1'b0;
    edge1();
    edge1();
    chk_all("t1_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk_all("t1_idle", 0, 0, 0, 0);
    end
    chk("t1_no_tc", tc_count, 0);

    // 2: one-shot count 5..0 then hold in DONE
    load = 1'b1; load_val = 3'd5; mode = 1'b0; en = 1'b1;
    edge1();
    chk_all("t2_load", 5, 0, 1, 0);
    load = 1'b0;
    for (int e = 4; e >= 0; e--) begin
      edge1();
      chk_all("t2_cnt", e, (e == 0) ? 1 : 0, (e != 0) ? 1 : 0, (e == 0) ? 1 : 0);
    end
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk_all("t2_done", 0, 0, 0, 1);
    end

    // 3: auto-reload period 3
    load = 1'b1; load_val = 3'd3; mode = 1'b1; en = 1'b1;
    edge1();
    chk_all("t3_load", 3, 0, 1, 0);
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      edge1();
      chk_all("t3_cnt", 2 - (i % 3) + ((i % 3 == 2) ? 3 : 0), (i % 3 == 2) ? 1 : 0, 1, 0);
    end

    // 4: pause at q=4
    load = 1'b1; load_val = 3'd6; mode = 1'b0; en = 1'b1;
    edge1();
    chk_all("t4_load", 6, 0, 1, 0);
    load = 1'b0;
    edge1();
    edge1();
    chk_all("t4_q4", 4, 0, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk_all("t4_pause", 4, 0, 1, 0);
    end
    en = 1'b1;
    for (int e = 3; e >= 0; e--) begin
      edge1();
      chk_all("t4_resume", e, (e == 0) ? 1 : 0, (e != 0) ? 1 : 0, (e == 0) ? 1 : 0);
    end

    // 5: load on the terminal edge wins
    load = 1'b1; load_val = 3'd2; mode = 1'b0; en = 1'b1;
    edge1();
    load = 1'b0;
    edge1();
    chk_all("t5_q1", 1, 0, 1, 0);
    load = 1'b1; load_val = 3'd7;
    edge1();
    chk_all("t5_reload", 7, 0, 1, 0);
    load = 1'b0;
    edge1();
    chk_all("t5_next", 6, 0, 1, 0);

    // 6: zero load, then full 7..0, then DONE ignores mode/en
    load = 1'b1; load_val = 3'd0;
    edge1();
    chk_all("t6_load0", 0, 0, 0, 0);
    load_val = 3'd7; mode = 1'b0; en = 1'b1;
    edge1();
    chk_all("t6_load7", 7, 0, 1, 0);
    load = 1'b0;
    tc_count = 0;
    for (int e = 6; e >= 0; e--) begin
      edge1();
      chk_all("t6_cnt", e, (e == 0) ? 1 : 0, (e != 0) ? 1 : 0, (e == 0) ? 1 : 0);
    end
    chk("t6_tc_count", tc_count, 1);
    mode = 1'b1; en = 1'b0;
    edge1();
    chk_all("t6_done_a", 0, 0, 0, 1);
    mode = 1'b0; en = 1'b1;
    edge1();
    chk_all("t6_done_b", 0, 0, 0, 1);
    mode = 1'b1;
    edge1();
    chk_all("t6_done_c", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
